// File: rtl/line_raster_if.sv
// -----------------------------------------------------------------------------
// line_raster_if
// Command and pixel-stream bundle for line_raster_ctrl.
//   start            command strobe (sampled only while the controller is idle)
//   x0,y0,x1,y1      signed segment endpoints, CW bits
//   busy             controller is not idle
//   pix_valid/ready  pixel handshake towards the fragment/pixel-write stage
//   pix_x,pix_y      signed pixel coordinate, CW bits
//   pix_last         marks the final pixel of the segment
//   done             one-cycle pulse once the final pixel has been accepted
// Modports: master = command issuer / pixel consumer, slave = controller.
// -----------------------------------------------------------------------------
interface line_raster_if #(
  parameter int CW = 10
);
  logic                 start;
  logic signed [CW-1:0] x0;
  logic signed [CW-1:0] y0;
  logic signed [CW-1:0] x1;
  logic signed [CW-1:0] y1;
  logic                 busy;
  logic                 pix_valid;
  logic                 pix_ready;
  logic signed [CW-1:0] pix_x;
  logic signed [CW-1:0] pix_y;
  logic                 pix_last;
  logic                 done;

  modport master (
    output start, x0, y0, x1, y1, pix_ready,
    input  busy, pix_valid, pix_x, pix_y, pix_last, done
  );

  modport slave (
    input  start, x0, y0, x1, y1, pix_ready,
    output busy, pix_valid, pix_x, pix_y, pix_last, done
  );
endinterface

// File: rtl/line_raster_ctrl.sv
// -----------------------------------------------------------------------------
// line_raster_ctrl
// Sequential Bresenham line walker. One segment per command: the segment is
// normalised so the major axis ("a") ascends by one per pixel and the minor
// axis ("b") steps by dir whenever the decision term is positive. Pixels are
// streamed out with a valid/ready handshake, one per cycle when ready is held.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  line_raster_if.slave (command inputs, pixel stream, busy/done)
// Parameters: CW coordinate width, EW decision-term width (>= CW+3).
// -----------------------------------------------------------------------------
module line_raster_ctrl #(
  parameter int CW = 10,
  parameter int EW = 13
) (
  input logic          clk,
  input logic          rst,
  line_raster_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, FIN} state_t;

  localparam logic signed [CW:0]   ONE      = 1;
  localparam logic signed [CW:0]   C_ZERO   = '0;
  localparam logic signed [EW-1:0] ERR_ZERO = '0;

  state_t state;

  // Latched command endpoints.
  logic signed [CW-1:0] x0_q, y0_q, x1_q, y1_q;

  // Walk state: current (a,b), final a, decision term and its increments.
  logic signed [CW:0]   a, b, a_end;
  logic signed [EW-1:0] err, two_da, two_db;
  logic                 steep, dir_neg;

  // ---------------------------------------------------------------------------
  // Segment normalisation, evaluated from the latched endpoints during SETUP.
  // All differences are CW+1 bits so full-range endpoints cannot overflow.
  // ---------------------------------------------------------------------------
  logic signed [CW:0]   s_ex0, s_ey0, s_ex1, s_ey1;
  logic signed [CW:0]   s_dx, s_dy, s_adx, s_ady;
  logic signed [CW:0]   s_pa0, s_pb0, s_pa1, s_pb1;
  logic signed [CW:0]   s_a0, s_b0, s_a1, s_b1;
  logic signed [CW:0]   s_da, s_dbr, s_db;
  logic signed [EW-1:0] s_two_da, s_two_db;
  logic                 s_steep, s_swap;

  assign s_ex0 = {x0_q[CW-1], x0_q};
  assign s_ey0 = {y0_q[CW-1], y0_q};
  assign s_ex1 = {x1_q[CW-1], x1_q};
  assign s_ey1 = {y1_q[CW-1], y1_q};

  assign s_dx  = s_ex1 - s_ex0;
  assign s_dy  = s_ey1 - s_ey0;
  assign s_adx = (s_dx < C_ZERO) ? -s_dx : s_dx;
  assign s_ady = (s_dy < C_ZERO) ? -s_dy : s_dy;
  assign s_steep = s_ady > s_adx;

  // Steep lines walk along Y, so the roles of the axes are exchanged.
  assign s_pa0 = s_steep ? s_ey0 : s_ex0;
  assign s_pb0 = s_steep ? s_ex0 : s_ey0;
  assign s_pa1 = s_steep ? s_ey1 : s_ex1;
  assign s_pb1 = s_steep ? s_ex1 : s_ey1;

  // Start from the endpoint with the lower major-axis coordinate.
  assign s_swap = s_pa0 > s_pa1;
  assign s_a0   = s_swap ? s_pa1 : s_pa0;
  assign s_b0   = s_swap ? s_pb1 : s_pb0;
  assign s_a1   = s_swap ? s_pa0 : s_pa1;
  assign s_b1   = s_swap ? s_pb0 : s_pb1;

  assign s_da  = s_a1 - s_a0;
  assign s_dbr = s_b1 - s_b0;
  assign s_db  = (s_dbr < C_ZERO) ? -s_dbr : s_dbr;

  assign s_two_da = EW'(s_da) <<< 1;
  assign s_two_db = EW'(s_db) <<< 1;

  // ---------------------------------------------------------------------------
  // Next pixel along the walk, applied when the current pixel is accepted.
  // ---------------------------------------------------------------------------
  logic signed [CW:0]   na, nb;
  logic signed [EW-1:0] nerr;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    na   = a + ONE;
    nb   = b;
    nerr = err + two_db;
    if (err > ERR_ZERO) begin
      nb   = dir_neg ? (b - ONE) : (b + ONE);
      nerr = err + two_db - two_da;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments so every register
  // samples values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      x0_q          <= '0;
      y0_q          <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      a             <= '0;
      b             <= '0;
      a_end         <= '0;
      err           <= '0;
      two_da        <= '0;
      two_db        <= '0;
      steep         <= 1'b0;
      dir_neg       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.pix_valid <= 1'b0;
      bus.pix_last  <= 1'b0;
      bus.pix_x     <= '0;
      bus.pix_y     <= '0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            x0_q     <= bus.x0;
            y0_q     <= bus.y0;
            x1_q     <= bus.x1;
            y1_q     <= bus.y1;
            bus.busy <= 1'b1;
            state    <= SETUP;
          end
        end

        SETUP: begin
          steep         <= s_steep;
          dir_neg       <= s_dbr < C_ZERO;
          a             <= s_a0;
          b             <= s_b0;
          a_end         <= s_a1;
          err           <= s_two_db - EW'(s_da);
          two_da        <= s_two_da;
          two_db        <= s_two_db;
          bus.pix_valid <= 1'b1;
          bus.pix_x     <= s_steep ? s_b0[CW-1:0] : s_a0[CW-1:0];
          bus.pix_y     <= s_steep ? s_a0[CW-1:0] : s_b0[CW-1:0];
          bus.pix_last  <= s_a0 == s_a1;
          state         <= DRAW;
        end

        DRAW: begin
          if (bus.pix_ready) begin
            if (a == a_end) begin
              bus.pix_valid <= 1'b0;
              bus.pix_last  <= 1'b0;
              bus.done      <= 1'b1;
              state         <= FIN;
            end else begin
              a            <= na;
              b            <= nb;
              err          <= nerr;
              bus.pix_x    <= steep ? nb[CW-1:0] : na[CW-1:0];
              bus.pix_y    <= steep ? na[CW-1:0] : nb[CW-1:0];
              bus.pix_last <= na == a_end;
            end
          end
        end

        FIN: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_raster_ctrl
// Directed bench for line_raster_ctrl. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_line_raster_ctrl;

  localparam int CW = 10;
  localparam int EW = 13;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_raster_if #(.CW(CW)) bus ();

  line_raster_ctrl #(.CW(CW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Expected pixel sequence for the segment currently being drawn.
  int exp_x[$];
  int exp_y[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input int lx0, input int ly0, input int lx1, input int ly1);
    bus.x0    = CW'(lx0);
    bus.y0    = CW'(ly0);
    bus.x1    = CW'(lx1);
    bus.y1    = CW'(ly1);
    bus.start = 1'b1;
  endtask

  // Draws one segment and compares it against exp_x/exp_y.
  // mode 0: pix_ready held high. mode 1: pix_ready 1,0,0 repeating plus a
  // stray start pulse with different endpoints while the line is in progress.
  task automatic run_line(input string name, input int lx0, input int ly0,
                          input int lx1, input int ly1, input int mode);
    int  idx;
    int  cyc;
    int  n;
    logic rdy;
    n = exp_x.size();
    bus.pix_ready = 1'b0;
    @(negedge clk);
    issue(lx0, ly0, lx1, ly1);
    @(negedge clk);
    bus.start = 1'b0;
    check({name, ".lat1_valid"}, bus.pix_valid, 1'b0);
    check({name, ".lat1_busy"}, bus.busy, 1'b1);
    @(negedge clk);
    check({name, ".lat2_valid"}, bus.pix_valid, 1'b1);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 5000) begin
      if (bus.pix_valid !== 1'b1) begin
        check({name, ".valid"}, bus.pix_valid, 1'b1);
        break;
      end
      check({name, ".x"}, bus.pix_x, exp_x[idx]);
      check({name, ".y"}, bus.pix_y, exp_y[idx]);
      check({name, ".last"}, bus.pix_last, idx == n - 1);
      rdy = (mode == 0) || (cyc % 3 == 0);
      bus.start = 1'b0;
      if (mode == 1 && cyc == 2) issue(9, 9, -9, -9);
      bus.pix_ready = rdy;
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    bus.pix_ready = 1'b0;
    bus.start     = 1'b0;
    check({name, ".count"}, idx, n);
    check({name, ".done_pulse"}, bus.done, 1'b1);
    check({name, ".fin_valid"}, bus.pix_valid, 1'b0);
    @(negedge clk);
    check({name, ".done_clear"}, bus.done, 1'b0);
    check({name, ".idle_busy"}, bus.busy, 1'b0);
  endtask

  task automatic load_test1();
    exp_x = {0, 1, 2, 3, 4};
    exp_y = {0, 0, 1, 1, 2};
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.pix_ready = 1'b0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.x1 = '0;
    bus.y1 = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst.busy", bus.busy, 1'b0);
    check("rst.valid", bus.pix_valid, 1'b0);
    check("rst.last", bus.pix_last, 1'b0);
    check("rst.done", bus.done, 1'b0);
    check("rst.pix_x", bus.pix_x, 0);
    check("rst.pix_y", bus.pix_y, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.busy", bus.busy, 1'b0);

    // Shallow line.
    load_test1();
    run_line("shallow", 0, 0, 4, 2, 0);

    // Steep line, both directions.
    exp_x = {0, 0, 1, 1};
    exp_y = {0, 1, 2, 3};
    run_line("steep", 0, 0, 1, 3, 0);
    run_line("steep_rev", 1, 3, 0, 0, 0);

    // Negative slope and reversed shallow line.
    exp_x = {0, 1, 2, 3};
    exp_y = {0, -1, -2, -3};
    run_line("neg_slope", 0, 0, 3, -3, 0);
    load_test1();
    run_line("shallow_rev", 4, 2, 0, 0, 0);

    // Backpressure with an ignored mid-line start.
    load_test1();
    run_line("backpressure", 0, 0, 4, 2, 1);

    // Degenerate segment.
    exp_x = {5};
    exp_y = {-7};
    run_line("degenerate", 5, -7, 5, -7, 0);

    // Full-range diagonal.
    exp_x.delete();
    exp_y.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_x.push_back(i - 512);
      exp_y.push_back(i - 512);
    end
    run_line("full_range", -512, -512, 511, 511, 0);

    // Reset while the third pixel is presented.
    @(negedge clk);
    issue(0, 0, 4, 2);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.pix_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid.third_x", bus.pix_x, 2);
    check("rst_mid.third_y", bus.pix_y, 1);
    rst           = 1'b1;
    bus.pix_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.valid", bus.pix_valid, 1'b0);
    check("rst_mid.busy", bus.busy, 1'b0);
    check("rst_mid.done", bus.done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid.no_done", bus.done, 1'b0);
      check("rst_mid.no_valid", bus.pix_valid, 1'b0);
    end
    load_test1();
    run_line("after_reset", 0, 0, 4, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_raster_ctrl.md
Name: line_raster_ctrl

Overview:
Sequential line-drawing controller for the rasterizer.
- Accepts one line segment (two signed 10-bit screen endpoints) per command.
- Normalises the segment to a unit-step-major-axis form: swaps axes for steep lines, swaps endpoints so the major axis ascends.
- Walks the segment with an incremental integer Bresenham decision term.
- Emits one pixel coordinate per accepted handshake to the downstream fragment/pixel-write stage.

Parameters:
CW, 10, coordinate width (signed)
EW, 13, decision/error register width (signed); must be at least CW+3

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  command strobe; sampled only in IDLE
x0  input  CW  start point X, signed
y0  input  CW  start point Y, signed
x1  input  CW  end point X, signed
y1  input  CW  end point Y, signed
busy  output  1  high in any state other than IDLE
pix_valid  output  1  pix_x/pix_y hold a valid pixel
pix_ready  input  1  downstream accepts pixel this cycle
pix_x  output  CW  pixel X, signed
pix_y  output  CW  pixel Y, signed
pix_last  output  1  qualifies final pixel of segment (valid only with pix_valid)
done  output  1  one-cycle pulse after final pixel accepted

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE; busy, pix_valid, pix_last, done = 0; pix_x, pix_y = 0; all internal registers = 0.
- Reset mid-operation: abandons the segment immediately. No further pixels are emitted and no done pulse is generated.
- States: IDLE, SETUP, DRAW, FIN.
- IDLE:
  - start=1 latches x0..y1 and moves to SETUP.
  - start=0 stays in IDLE.
- SETUP (exactly 1 cycle):
  - dx=x1-x0, dy=y1-y0 (CW+1 bits, signed).
  - steep = |dy| > |dx|.
  - If steep, (a,b) := (y,x) for both endpoints; otherwise (a,b) := (x,y).
  - If a0 > a1, swap the two endpoints.
  - da = a1-a0 (>=0); db = |b1-b0|; dir = +1 if b1>=b0, else -1.
  - err = 2*db - da, sign-extended to EW.
  - Cur (a,b) = (a0,b0). Next state is DRAW.
- DRAW:
  - pix_valid=1.
  - pix_x/pix_y = (a,b) if not steep, (b,a) if steep.
  - pix_last = (a==a1).
  - Outputs stay stable while pix_ready=0.
  - On pix_valid && pix_ready with a==a1: go to FIN.
  - On pix_valid && pix_ready with a!=a1:
    - a += 1.
    - If err > 0: b += dir, err += 2*db - 2*da.
    - Else: err += 2*db.
    - The new pixel is presented the following cycle.
  - Pixel throughput: 1/cycle under continuous pix_ready.
- FIN: done=1 for one cycle; pix_valid=0; next state is IDLE.
- Latency: start to first pix_valid is 2 cycles (IDLE→SETUP→DRAW).
- Pixel count is da+1. A degenerate segment (identical endpoints) emits exactly one pixel with pix_last=1.
- Emission order: from the endpoint with the lower major-axis coordinate. Pixels may come out in reverse of the command order; downstream must not depend on order.
- start while busy is ignored; no command queueing.
- Arithmetic:
  - All coordinate math is signed CW+1 bits; err is signed EW bits.
  - Full-range endpoints (-512..511) must not overflow.
  - Coordinates never leave the [min,max] span of the endpoints.
- pix_ready asserted outside DRAW has no effect.

Test Plan:
1. Shallow line: start (0,0)->(4,2), pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2), one per cycle; pix_last on (4,2); done one cycle later; first pix_valid 2 cycles after start.
2. Steep line: (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3). Reversed (1,3)->(0,0) -> same sequence.
3. Negative slope / reversed: (0,0)->(3,-3) -> (0,0),(1,-1),(2,-2),(3,-3). (4,2)->(0,0) -> identical pixels to test 1.
4. Backpressure: test 1 with pix_ready toggling 1,0,0,1,... -> pix_x/pix_y/pix_last stable while stalled; same 5 pixels; no duplicates or drops. A start pulse mid-line is ignored.
5. Degenerate and extremes:
   - (5,-7)->(5,-7) -> single pixel (5,-7) with pix_last=1, then done.
   - (-512,-512)->(511,511) -> 1024 pixels with pix_x==pix_y; last pixel (511,511).
6. Reset mid-line: assert rst during the 3rd pixel of test 1 -> next cycle pix_valid=0, busy=0, no done. A fresh start then reproduces test 1 exactly.
